// File: rtl/parking_occupancy_timer.sv
// parking_occupancy_timer: 4-slot car park occupancy tracker with per-slot
// mm:ss parking timers and an entry/exit gate controller. It feeds capacity,
// free slot, last session time and mode to the multiplexed display stage.
// Optional macro SYNC_INPUTS_EN puts the level inputs through 2-flop
// synchronizers before edge detection.
module parking_occupancy_timer #(
  parameter int TICKS_PER_SEC = 500,
  parameter int GATE_TICKS    = 1000
) (
  input  logic       clk_500Hz,
  input  logic       reset,
  input  logic       entry_sensor,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  input  logic       mode_btn,
  output logic [2:0] capacity,
  output logic [1:0] empty_slot,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       mode,
  output logic       full,
  output logic       gate_open
);

  localparam int              TW        = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0]   TICK_MAX  = TW'(TICKS_PER_SEC - 1);
  localparam logic [15:0]     GATE_LOAD = 16'(GATE_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN_IN, S_OPEN_OUT} gate_state_t;

  logic       w_entry_in, w_exit_in, w_mode_in;
  logic [1:0] w_slot_in;

`ifdef SYNC_INPUTS_EN
  logic [4:0] r_sync1, r_sync2;

  // Two-flop synchronizer; exit_slot travels with exit_req so they stay aligned
  always_ff @(posedge clk_500Hz or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {mode_btn, exit_slot, exit_req, entry_sensor};
      r_sync2 <= r_sync1;
    end
  end
  assign {w_mode_in, w_slot_in, w_exit_in, w_entry_in} = r_sync2;
`else
  assign {w_mode_in, w_slot_in, w_exit_in, w_entry_in} =
         {mode_btn, exit_slot, exit_req, entry_sensor};
`endif

  logic r_entry_prev, r_exit_prev, r_mode_prev;
  logic w_entry_rq, w_exit_rq, w_mode_rq;

  // Previous-value history for rising-edge detection
  always_ff @(posedge clk_500Hz or posedge reset) begin
    if (reset) begin
      r_entry_prev <= 1'b0;
      r_exit_prev  <= 1'b0;
      r_mode_prev  <= 1'b0;
    end else begin
      r_entry_prev <= w_entry_in;
      r_exit_prev  <= w_exit_in;
      r_mode_prev  <= w_mode_in;
    end
  end

  assign w_entry_rq = w_entry_in & ~r_entry_prev;
  assign w_exit_rq  = w_exit_in  & ~r_exit_prev;
  assign w_mode_rq  = w_mode_in  & ~r_mode_prev;

  logic [TW-1:0] r_tick_cnt;
  logic          w_sec_tick;

  // One-second prescaler; the pulse is the last count of each period
  always_ff @(posedge clk_500Hz or posedge reset) begin
    if (reset)                  r_tick_cnt <= '0;
    else if (r_tick_cnt == TICK_MAX) r_tick_cnt <= '0;
    else                        r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  assign w_sec_tick = (r_tick_cnt == TICK_MAX);

  logic [3:0]  r_occupied;
  logic [5:0]  r_tmin [4];
  logic [5:0]  r_tsec [4];
  logic [2:0]  w_free_cnt;
  logic [1:0]  w_free_idx;
  logic        w_any_free;

  // Free-slot count and lowest free index from the live occupancy map
  always_comb begin
    w_free_cnt = '0;
    w_free_idx = '0;
    w_any_free = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_occupied[i]) begin
        w_free_cnt = w_free_cnt + 3'd1;
        w_free_idx = 2'(i);
        w_any_free = 1'b1;
      end
    end
  end

  logic [2:0] r_capacity;
  logic [1:0] r_empty_slot;

  // Display-facing occupancy summary, one cycle behind the occupancy map
  always_ff @(posedge clk_500Hz or posedge reset) begin
    if (reset) begin
      r_capacity   <= 3'd4;
      r_empty_slot <= 2'd0;
    end else begin
      r_capacity   <= w_free_cnt;
      r_empty_slot <= w_free_idx;
    end
  end

  gate_state_t r_state;
  logic [15:0] r_gate_cnt;
  logic        r_gate_open;
  logic [5:0]  r_minutes, r_seconds;
  logic        r_mode;

  // Slot timers, gate FSM, occupancy and session readout; a gate action on a
  // slot overrides that slot's tick update (later NBA wins)
  always_ff @(posedge clk_500Hz or posedge reset) begin
    if (reset) begin
      r_occupied  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_tmin[i] <= '0;
        r_tsec[i] <= '0;
      end
      r_state     <= S_IDLE;
      r_gate_cnt  <= '0;
      r_gate_open <= 1'b0;
      r_minutes   <= '0;
      r_seconds   <= '0;
      r_mode      <= 1'b0;
    end else begin
      if (w_mode_rq) r_mode <= ~r_mode;

      if (w_sec_tick) begin
        for (int i = 0; i < 4; i++) begin
          if (r_occupied[i] && !(r_tmin[i] == 6'd59 && r_tsec[i] == 6'd59)) begin
            if (r_tsec[i] == 6'd59) begin
              r_tsec[i] <= 6'd0;
              r_tmin[i] <= r_tmin[i] + 6'd1;
            end else begin
              r_tsec[i] <= r_tsec[i] + 6'd1;
            end
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          // An exit request claims the cycle; a coincident entry is dropped
          if (w_exit_rq) begin
            if (r_occupied[w_slot_in]) begin
              r_minutes             <= r_tmin[w_slot_in];
              r_seconds             <= r_tsec[w_slot_in];
              r_occupied[w_slot_in] <= 1'b0;
              r_tmin[w_slot_in]     <= '0;
              r_tsec[w_slot_in]     <= '0;
              r_state               <= S_OPEN_OUT;
              r_gate_cnt            <= GATE_LOAD;
              r_gate_open           <= 1'b1;
            end
          end else if (w_entry_rq && w_any_free) begin
            r_occupied[w_free_idx] <= 1'b1;
            r_tmin[w_free_idx]     <= '0;
            r_tsec[w_free_idx]     <= '0;
            r_state                <= S_OPEN_IN;
            r_gate_cnt             <= GATE_LOAD;
            r_gate_open            <= 1'b1;
          end
        end
        default: begin
          if (r_gate_cnt == 16'd0) begin
            r_state     <= S_IDLE;
            r_gate_open <= 1'b0;
          end else begin
            r_gate_cnt  <= r_gate_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  assign capacity   = r_capacity;
  assign empty_slot = r_empty_slot;
  assign full       = (r_capacity == 3'd0);
  assign minutes    = r_minutes;
  assign seconds    = r_seconds;
  assign mode       = r_mode;
  assign gate_open  = r_gate_open;

endmodule

// File: tb/tb_parking_occupancy_timer.sv
// Bench for parking_occupancy_timer: a seconds-based occupancy model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_parking_occupancy_timer;
  localparam int TPS = 4;
  localparam int GT  = 3;

  logic       clk = 1'b0, rst = 1'b1, ent = 1'b0, ex = 1'b0, md = 1'b0;
  logic [1:0] exs = 2'd0;
  logic [2:0] capacity;
  logic [1:0] empty_slot;
  logic [5:0] minutes, seconds;
  logic       mode, full, gate_open;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  parking_occupancy_timer #(.TICKS_PER_SEC(TPS), .GATE_TICKS(GT)) dut (
    .clk_500Hz(clk), .reset(rst), .entry_sensor(ent), .exit_req(ex),
    .exit_slot(exs), .mode_btn(md), .capacity(capacity), .empty_slot(empty_slot),
    .minutes(minutes), .seconds(seconds), .mode(mode), .full(full),
    .gate_open(gate_open)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy as a bit per slot, parking time as elapsed seconds
  bit m_occ [4];
  int m_el  [4];
  int m_dur, m_gate, m_cap, m_empty, m_cyc;
  bit m_mode, m_pe, m_px, m_pm;
  bit e_rq, x_rq, d_rq, tk, found;
  int dur_old, free_n, free_i;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_occ[i] = 0; m_el[i] = 0; end
      m_dur = 0; m_gate = 0; m_cap = 4; m_empty = 0; m_cyc = 0;
      m_mode = 0; m_pe = 0; m_px = 0; m_pm = 0;
    end else begin
      e_rq = ent && !m_pe; x_rq = ex && !m_px; d_rq = md && !m_pm;
      m_pe = ent; m_px = ex; m_pm = md;
      tk = (m_cyc % TPS) == TPS - 1;
      m_cyc++;
      free_n = 0; free_i = 0; found = 0;
      for (int i = 0; i < 4; i++)
        if (!m_occ[i]) begin
          free_n++;
          if (!found) begin free_i = i; found = 1; end
        end
      m_cap = free_n; m_empty = free_i;
      dur_old = m_el[exs];
      if (tk)
        for (int i = 0; i < 4; i++)
          if (m_occ[i] && m_el[i] < 3599) m_el[i]++;
      if (d_rq) m_mode = !m_mode;
      if (m_gate > 0) m_gate--;
      else if (x_rq) begin
        if (m_occ[exs]) begin
          m_dur = dur_old; m_occ[exs] = 0; m_el[exs] = 0; m_gate = GT;
        end
      end else if (e_rq && free_n > 0) begin
        m_occ[free_i] = 1; m_el[free_i] = 0; m_gate = GT;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_capacity",   32'(capacity),   32'(m_cap));
      chk("m_empty_slot", 32'(empty_slot), 32'(m_empty));
      chk("m_full",       32'(full),       32'(m_cap == 0));
      chk("m_minutes",    32'(minutes),    32'(m_dur / 60));
      chk("m_seconds",    32'(seconds),    32'(m_dur % 60));
      chk("m_mode",       32'(mode),       32'(m_mode));
      chk("m_gate_open",  32'(gate_open),  32'(m_gate > 0));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_capacity"},   32'(capacity),   32'd4);
    chk({tag, "_empty_slot"}, 32'(empty_slot), 32'd0);
    chk({tag, "_full"},       32'(full),       32'd0);
    chk({tag, "_minutes"},    32'(minutes),    32'd0);
    chk({tag, "_seconds"},    32'(seconds),    32'd0);
    chk({tag, "_mode"},       32'(mode),       32'd0);
    chk({tag, "_gate_open"},  32'(gate_open),  32'd0);
  endtask

  task automatic pulse_entry;
    ent = 1'b1; step(1); ent = 1'b0;
  endtask

  task automatic entry_and_count(output int n);
    n = 0;
    pulse_entry();
    n += int'(gate_open);
    repeat (5) begin step(1); n += int'(gate_open); end
  endtask

  task automatic pulse_exit(input logic [1:0] s);
    ex = 1'b1; exs = s; step(1); ex = 1'b0; step(5);
  endtask

  initial begin
    int n;
    int exp_e [4];
    exp_e = '{1, 2, 3, 0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step(2);
    check_reset_vals("reset");

    // Fill the park
    for (int k = 0; k < 4; k++) begin
      entry_and_count(n);
      chk("fill_gate_cycles", 32'(n), 32'd3);
      chk("fill_empty_slot", 32'(empty_slot), 32'(exp_e[k]));
      chk("fill_capacity", 32'(capacity), 32'(3 - k));
    end
    chk("fill_full", 32'(full), 32'd1);

    // Entry while full is ignored
    entry_and_count(n);
    chk("full_entry_gate_cycles", 32'(n), 32'd0);
    chk("full_entry_capacity", 32'(capacity), 32'd0);

    for (int k = 0; k < 4; k++) pulse_exit(2'(k));
    chk("emptied_capacity", 32'(capacity), 32'd4);

    // 65 s session in slot 0
    pulse_entry();
    step(260);
    pulse_exit(2'd0);
    chk("session_minutes", 32'(minutes), 32'd1);
    chk("session_seconds", 32'(seconds), 32'd5);
    chk("session_capacity", 32'(capacity), 32'd4);

    // Saturation beyond an hour
    pulse_entry();
    step(3700 * TPS);
    pulse_exit(2'd0);
    chk("sat_minutes", 32'(minutes), 32'd59);
    chk("sat_seconds", 32'(seconds), 32'd59);

    // Simultaneous entry and exit: exit wins
    repeat (3) entry_and_count(n);
    ent = 1'b1; ex = 1'b1; exs = 2'd2; step(1); ent = 1'b0; ex = 1'b0;
    chk("simul_gate_open", 32'(gate_open), 32'd1);
    step(1);
    chk("simul_capacity", 32'(capacity), 32'd2);
    chk("simul_empty_slot", 32'(empty_slot), 32'd2);
    step(5);

    // Second entry while gate opening is dropped
    ent = 1'b1; step(1); ent = 1'b0; step(1); ent = 1'b1; step(1); ent = 1'b0;
    step(6);
    chk("drop_capacity", 32'(capacity), 32'd1);
    chk("drop_empty_slot", 32'(empty_slot), 32'd3);

    // Mode toggles twice while the gate is open
    ent = 1'b1; step(1); ent = 1'b0; md = 1'b1; step(1);
    chk("mode_first", 32'(mode), 32'd1);
    chk("mode_first_gate", 32'(gate_open), 32'd1);
    md = 1'b0; step(1);
    chk("mode_second_gate", 32'(gate_open), 32'd1);
    md = 1'b1; step(1);
    chk("mode_second", 32'(mode), 32'd0);
    md = 1'b0; step(5);

    // Async reset in the middle of OPEN_IN
    md = 1'b1; step(1); md = 1'b0; step(1);
    chk("pre_reset_mode", 32'(mode), 32'd1);
    pulse_exit(2'd1);
    pulse_entry();
    chk("pre_reset_gate", 32'(gate_open), 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_vals("async_reset");
    step(1);
    rst = 1'b0;
    step(3);
    check_reset_vals("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parking_occupancy_timer.md
Name: parking_occupancy_timer

Overview:
- Upstream producer for the 4-digit multiplexed display stage.
- Tracks occupancy of a 4-slot car park and allocates a slot on each entry.
- Runs a per-slot mm:ss parking timer and drives the entry/exit gate.
- Outputs capacity, empty_slot, minutes, seconds and mode directly to the display stage.

Parameters:
- TICKS_PER_SEC, 500, clk_500Hz cycles per one-second tick (must be ≥2).
- GATE_TICKS, 1000, cycles the gate stays open per accepted event.

Ports:
- clk_500Hz  input  1  system clock, 500 Hz.
- reset  input  1  asynchronous, active-high reset.
- entry_sensor  input  1  level input; each rising edge is an entry request.
- exit_req  input  1  level input; each rising edge is an exit request.
- exit_slot  input  2  slot index of the exiting car; sampled on the exit_req rising edge.
- mode_btn  input  1  level input; each rising edge toggles mode.
- capacity  output  3  number of free slots, 0..4.
- empty_slot  output  2  lowest-index free slot; 0 when the park is full.
- minutes  output  6  duration of the last completed session, minutes 0..59.
- seconds  output  6  duration of the last completed session, seconds 0..59.
- mode  output  1  display mode: 0 = occupancy, 1 = time.
- full  output  1  high when capacity == 0.
- gate_open  output  1  high while the gate FSM is not IDLE.

Behaviour:
Reset values:
- occupied[3:0]=0, capacity=4, empty_slot=0, full=0.
- minutes=0, seconds=0, mode=0, gate_open=0.
- All slot timers = 00:00; tick counter = 0; gate FSM = IDLE.
- Edge-detect history registers = 0.
- Reset asserted mid-session discards all state immediately.

Edge detection:
- Each of entry_sensor, exit_req and mode_btn has a registered previous value.
- A request is raised when current=1 and previous=0.
- A request is acted on in the same cycle it is raised; the resulting state updates at the next clock edge.

Tick counter:
- Counts 0..TICKS_PER_SEC-1, then wraps to 0.
- sec_tick is a one-cycle pulse in the cycle where the count equals TICKS_PER_SEC-1.

Slot timers:
- 4 timers, each 6-bit minutes plus 6-bit seconds.
- On sec_tick, every occupied slot advances: seconds 59 wraps to 0 and minutes increments.
- A timer saturates at 59:59 and holds there.
- Free slots hold their value.

Gate FSM:
- States: IDLE, OPEN_IN, OPEN_OUT.
- A 16-bit cycle counter loads GATE_TICKS-1 on entering OPEN_IN or OPEN_OUT, decrements each cycle, and returns the FSM to IDLE when it reaches 0.
- gate_open is high in OPEN_IN and OPEN_OUT.

IDLE, exit request:
- If occupied[exit_slot]=1: copy that slot's timer to minutes/seconds, clear the occupied bit, clear the slot's timer, go to OPEN_OUT.
- If the slot is not occupied: ignore the request and stay in IDLE.

IDLE, entry request:
- If capacity > 0: set occupied[empty_slot], reset that slot's timer to 00:00, go to OPEN_IN.
- If full: ignore the request; no state change.

Priority and drops:
- Simultaneous entry and exit requests in IDLE: exit wins and the entry request is dropped.
- Entry and exit requests raised while in OPEN_IN or OPEN_OUT are dropped (not queued).

Derived outputs:
- capacity = popcount(~occupied), registered.
- empty_slot = lowest index with occupied=0, registered.
- full = (capacity == 0).
- These update one cycle after the occupied change.

Mode:
- A mode_btn request toggles mode in any FSM state.

Optional Feature:
- Macro SYNC_INPUTS_EN.
- Defined: entry_sensor, exit_req, exit_slot and mode_btn each pass through a 2-flop synchronizer (reset to 0) before edge detection, adding 2 cycles of request latency.
- Undefined: inputs feed edge detection directly, with zero added latency.

Test Plan:
All scenarios use TICKS_PER_SEC=4, GATE_TICKS=3, SYNC_INPUTS_EN undefined.
- Reset release -> capacity=4, empty_slot=0, full=0, minutes=0, seconds=0, mode=0, gate_open=0.
- 4 entry pulses, each spaced ≥5 cycles -> empty_slot sequence 1,2,3,0; capacity 3,2,1,0; full=1 after the 4th; gate_open high for exactly 3 cycles per entry.
- Fifth entry pulse while full -> no change to occupied, capacity stays 0, gate_open stays 0.
- Entry into slot 0, wait 65 s of ticks (260 cycles), exit with exit_slot=0 -> minutes=1, seconds=5; capacity returns to 4.
- Slot held for >3600 s, then exit -> minutes=59, seconds=59 (saturation).
- Entry and exit (exit_slot=2, occupied) raised in the same IDLE cycle -> slot 2 freed, entry dropped, FSM enters OPEN_OUT.
- Second entry pulse raised during OPEN_IN -> dropped; capacity decrements only once.
- mode_btn pulsed twice while the gate is open -> mode goes 1 then 0.
- reset asserted mid OPEN_IN -> all outputs return to reset values immediately, without waiting for a clock edge.
